// File: rtl/soc_system_uart_pkg.sv
// Shared types and helpers for the SoC UART receive path.
package soc_system_uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

  // Bit-period counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned clks_per_bit);
    return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/soc_system_sync_bit.sv
// N-flop synchroniser for a single asynchronous input; resets to 1 (idle-high lines).
module soc_system_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {STAGES{1'b1}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/soc_system_uart_rx.sv
// 8N1 UART receiver feeding the data PIO; mid-bit sampling with strobe and error flags.
module soc_system_uart_rx
  import soc_system_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_strobe,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int unsigned    CW       = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     LAST_IDX = 3'(DATA_BITS - 1);

  logic                 w_rx_s;
  uart_rx_state_t       r_state;
  logic [CW-1:0]        r_cnt;
  logic [2:0]           r_idx;
  logic [DATA_BITS-1:0] r_sh;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_strobe;
  logic                 r_ferr;
  logic                 r_break;
  logic                 r_busy;

  soc_system_sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk  (clk),
    .i_rst_n(reset_n),
    .i_d    (rx),
    .o_q    (w_rx_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_sh     <= '0;
      r_data   <= '0;
      r_strobe <= 1'b0;
      r_ferr   <= 1'b0;
      r_break  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      r_ferr   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            r_state <= START;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        // Half a bit period here puts every later sample at mid-bit.
        START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= DATA;
              r_idx   <= '0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt       <= '0;
            r_sh[r_idx] <= w_rx_s;
            if (r_idx == LAST_IDX) begin
              r_state <= STOP;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        STOP: begin
          if (r_cnt == FULL_M1) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_data   <= r_sh;
              r_strobe <= 1'b1;
              r_state  <= IDLE;
              r_busy   <= 1'b0;
            end else begin
              r_ferr  <= 1'b1;
              r_break <= 1'b1;
              r_state <= BREAK;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        // A held-low line must return high before a new start is accepted.
        BREAK: begin
          if (w_rx_s) begin
            r_state <= IDLE;
            r_break <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_break <= 1'b0;
        end
      endcase
    end
  end

  assign data_out  = r_data;
  assign rx_strobe = r_strobe;
  assign frame_err = r_ferr;
  assign break_det = r_break;
  assign busy      = r_busy;

endmodule

// File: tb/tb_soc_system_uart_rx.sv
// Randomised self-checking bench for soc_system_uart_rx against a frame-level reference model.
`timescale 1ns/1ps
module tb_soc_system_uart_rx;

  localparam int unsigned CPB   = 16;
  localparam realtime     TCLK  = 10.0;
  localparam realtime     TBIT  = CPB * TCLK;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       rx_strobe;
  logic       frame_err;
  logic       break_det;
  logic       busy;

  int unsigned     n_checks = 0;
  int unsigned     n_errors = 0;
  longint unsigned cyc = 0;
  int unsigned     ferr_cnt = 0;
  logic [7:0]      strobe_q[$];
  longint unsigned strobe_t[$];

  soc_system_uart_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx       (rx),
    .data_out (data_out),
    .rx_strobe(rx_strobe),
    .frame_err(frame_err),
    .break_det(break_det),
    .busy     (busy)
  );

  always #(TCLK / 2) clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_strobe) begin
      strobe_q.push_back(data_out);
      strobe_t.push_back(cyc);
    end
    if (frame_err) ferr_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Keep line transitions well away from clock edges.
  task automatic align();
    @(posedge clk);
    #3;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input realtime bit_t);
    rx = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_t);
    end
    rx = stop_bit;
    #(bit_t);
  endtask

  function automatic logic [31:0] q_at(input int i);
    return (strobe_q.size() > i) ? 32'(strobe_q[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] gap_at(input int i);
    return (strobe_t.size() > i) ? 32'(strobe_t[i] - strobe_t[i-1]) : 32'hDEAD;
  endfunction

  initial begin
    int unsigned f0;
    logic [7:0]  exp_last;
    logic [7:0]  exp_q[$];
    int unsigned exp_ferr;
    logic [7:0]  b2b[3];

    // Reset state
    wait_cyc(3);
    check_eq("rst_data", 32'(data_out), 32'h0);
    check_eq("rst_strobe", 32'(rx_strobe), 32'h0);
    check_eq("rst_ferr", 32'(frame_err), 32'h0);
    check_eq("rst_break", 32'(break_det), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    @(negedge clk) reset_n = 1'b1;
    wait_cyc(3);

    // Single good frame
    strobe_q.delete();
    f0 = ferr_cnt;
    align();
    fork
      send_frame(8'hA5, 1'b1, TBIT);
      begin
        #(5 * TBIT);
        check_eq("a5_busy_mid", 32'(busy), 32'h1);
      end
    join
    wait_cyc(5);
    check_eq("a5_strobes", strobe_q.size(), 32'd1);
    check_eq("a5_data", 32'(data_out), 32'hA5);
    check_eq("a5_ferr", ferr_cnt - f0, 32'd0);
    check_eq("a5_busy_end", 32'(busy), 32'h0);

    // Back-to-back frames, no idle gap
    b2b = '{8'h00, 8'hFF, 8'h3C};
    strobe_q.delete();
    strobe_t.delete();
    align();
    for (int i = 0; i < 3; i++) send_frame(b2b[i], 1'b1, TBIT);
    wait_cyc(5);
    check_eq("b2b_count", strobe_q.size(), 32'd3);
    for (int i = 0; i < 3; i++) check_eq("b2b_data", q_at(i), 32'(b2b[i]));
    for (int i = 1; i < 3; i++) check_eq("b2b_gap", gap_at(i), 32'd160);
    check_eq("b2b_last", 32'(data_out), 32'h3C);

    // Short low glitch is a false start
    strobe_q.delete();
    align();
    rx = 1'b0;
    #(5 * TCLK);
    rx = 1'b1;
    wait_cyc(2);
    check_eq("glitch_busy_start", 32'(busy), 32'h1);
    wait_cyc(7);
    check_eq("glitch_busy_end", 32'(busy), 32'h0);
    check_eq("glitch_strobes", strobe_q.size(), 32'd0);
    check_eq("glitch_data", 32'(data_out), 32'h3C);

    // Framing error then held-low break
    strobe_q.delete();
    f0 = ferr_cnt;
    align();
    send_frame(8'h55, 1'b0, TBIT);
    wait_cyc(25);
    check_eq("brk_det", 32'(break_det), 32'h1);
    check_eq("brk_busy", 32'(busy), 32'h1);
    check_eq("brk_ferr", ferr_cnt - f0, 32'd1);
    check_eq("brk_data", 32'(data_out), 32'h3C);
    wait_cyc(25);
    rx = 1'b1;
    wait_cyc(6);
    check_eq("brk_release", 32'(break_det), 32'h0);
    check_eq("brk_busy_end", 32'(busy), 32'h0);
    check_eq("brk_ferr_once", ferr_cnt - f0, 32'd1);
    check_eq("brk_strobes", strobe_q.size(), 32'd0);
    align();
    send_frame(8'h12, 1'b1, TBIT);
    wait_cyc(5);
    check_eq("post_brk_data", 32'(data_out), 32'h12);
    check_eq("post_brk_strobes", strobe_q.size(), 32'd1);

    // Reset asserted during bit 4
    align();
    fork
      send_frame(8'h81, 1'b1, TBIT);
      begin
        #(5.5 * TBIT);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_data", 32'(data_out), 32'h0);
        check_eq("mid_rst_busy", 32'(busy), 32'h0);
        check_eq("mid_rst_break", 32'(break_det), 32'h0);
        check_eq("mid_rst_strobe", 32'(rx_strobe), 32'h0);
      end
    join
    @(negedge clk) reset_n = 1'b1;
    wait_cyc(3);
    strobe_q.delete();
    align();
    send_frame(8'h7E, 1'b1, TBIT);
    wait_cyc(5);
    check_eq("post_rst_data", 32'(data_out), 32'h7E);
    check_eq("post_rst_strobes", strobe_q.size(), 32'd1);

    // Baud tolerance +-3%
    for (int k = 0; k < 2; k++) begin
      strobe_q.delete();
      f0 = ferr_cnt;
      align();
      send_frame(8'hC3, 1'b1, (k == 0) ? 15.5 * TCLK : 16.5 * TCLK);
      wait_cyc(5);
      check_eq("tol_data", 32'(data_out), 32'hC3);
      check_eq("tol_ferr", ferr_cnt - f0, 32'd0);
    end

    // Random frames with random gaps and occasional bad stop bits
    exp_last = 8'hC3;
    exp_ferr = 0;
    strobe_q.delete();
    f0 = ferr_cnt;
    align();
    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      logic       bad;
      b   = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      if (bad) begin
        send_frame(b, 1'b0, TBIT);
        #(20 * TCLK);
        rx = 1'b1;
        #(6 * TCLK);
        exp_ferr++;
      end else begin
        send_frame(b, 1'b1, TBIT);
        exp_q.push_back(b);
        exp_last = b;
      end
      #($urandom_range(0, 30) * TCLK);
    end
    wait_cyc(5);
    check_eq("rnd_count", strobe_q.size(), exp_q.size());
    foreach (exp_q[i]) check_eq("rnd_data", q_at(i), 32'(exp_q[i]));
    check_eq("rnd_ferr", ferr_cnt - f0, exp_ferr);
    check_eq("rnd_last", 32'(data_out), 32'(exp_last));
    check_eq("rnd_busy", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
